ifft_serial: RTL

Memory-based radix-2 inverse FFT for the FFT accelerator path: accepts N complex frequency-domain samples over a valid/ready stream, runs log2(N) in-place decimation-in-time stages with a single time-shared butterfly, and streams N time-domain samples back out in natural order with a built-in 1/N scale. It is the inverse-direction companion of the parallel forward FFT unit. It sits between the accelerator's frequency-domain buffer and the core-facing result port.

---
 rtl/ifft_pkg.sv | 60 ++++++
 rtl/ifft_butterfly.sv | 52 +++++
 rtl/ifft_serial.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ifft_pkg.sv
// Shared types and elaboration-time helpers for the serial radix-2 inverse FFT.
// Twiddles come from a fixed-point Taylor series so no runtime trig is ever synthesized.
package ifft_pkg;

  typedef enum logic [1:0] {
    StLoad,
    StCompute,
    StUnload
  } ifft_state_e;

  // Twiddles carry two integer bits so +1.0 is representable exactly.
  localparam int unsigned TwIntBits = 2;

  // pi scaled by 2^28.
  localparam longint PiQ28 = 64'sd843314857;

  function automatic int unsigned tw_frac(input int unsigned width);
    return width - TwIntBits;
  endfunction

  function automatic int unsigned bitrev(input int unsigned v, input int unsigned bits);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < bits; i++) begin
      r = (r << 1) | ((v >> i) & 1);
    end
    return r;
  endfunction

  // cos or sin of 2*pi*m/n for m in [0, n/2), rounded to `frac` fraction bits.
  function automatic int tw_value(input int unsigned m, input int unsigned n,
                                  input int unsigned frac, input bit want_sin);
    longint      th;
    longint      x2;
    longint      term;
    longint      acc;
    longint      den;
    int unsigned mm;
    bit          neg;
    mm  = m;
    neg = 1'b0;
    // Fold angles above pi/2 back so the series stays small and accurate.
    if (4 * mm > n) begin
      mm  = n / 2 - mm;
      neg = !want_sin;
    end
    th   = (2 * PiQ28 * longint'(mm)) / longint'(n);
    x2   = (th * th) >>> 28;
    term = want_sin ? th : (64'sd1 <<< 28);
    acc  = term;
    for (int k = 1; k <= 12; k++) begin
      den  = want_sin ? longint'((2 * k) * (2 * k + 1)) : longint'((2 * k - 1) * (2 * k));
      term = -(((term * x2) >>> 28) / den);
      acc  = acc + term;
    end
    acc = (acc + (64'sd1 <<< (27 - frac))) >>> (28 - frac);
    return neg ? -int'(acc) : int'(acc);
  endfunction

endpackage

// File: rtl/ifft_butterfly.sv
// Combinational radix-2 DIT butterfly with per-stage halving and saturation.
module ifft_butterfly #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TW_FRAC = 14
) (
  input  logic [WIDTH-1:0] top_re_i,
  input  logic [WIDTH-1:0] top_im_i,
  input  logic [WIDTH-1:0] bot_re_i,
  input  logic [WIDTH-1:0] bot_im_i,
  input  logic [WIDTH-1:0] tw_re_i,
  input  logic [WIDTH-1:0] tw_im_i,
  output logic [WIDTH-1:0] a_re_o,
  output logic [WIDTH-1:0] a_im_o,
  output logic [WIDTH-1:0] b_re_o,
  output logic [WIDTH-1:0] b_im_o
);

  localparam int unsigned PW = 2 * WIDTH + 1;
  localparam int unsigned EW = WIDTH + 2;

  localparam logic signed [EW-1:0] MaxV = {3'b000, {(WIDTH - 1){1'b1}}};
  localparam logic signed [EW-1:0] MinV = {3'b111, {(WIDTH - 1){1'b0}}};

  function automatic logic [WIDTH-1:0] sat(input logic signed [EW-1:0] v);
    if (v > MaxV) return MaxV[WIDTH-1:0];
    if (v < MinV) return MinV[WIDTH-1:0];
    return v[WIDTH-1:0];
  endfunction

  logic signed [PW-1:0] br, bi, wr, wi;
  logic signed [PW-1:0] prod_re, prod_im;
  logic signed [EW-1:0] tr, ti, p_re, p_im;

  always_comb begin
    br      = PW'($signed(bot_re_i));
    bi      = PW'($signed(bot_im_i));
    wr      = PW'($signed(tw_re_i));
    wi      = PW'($signed(tw_im_i));
    prod_re = br * wr - bi * wi;
    prod_im = br * wi + bi * wr;
    // |bot * W| stays below 2^(WIDTH+1), so EW bits hold p and top +/- p.
    p_re    = EW'(prod_re >>> TW_FRAC);
    p_im    = EW'(prod_im >>> TW_FRAC);
    tr      = EW'($signed(top_re_i));
    ti      = EW'($signed(top_im_i));
    a_re_o  = sat((tr + p_re) >>> 1);
    a_im_o  = sat((ti + p_im) >>> 1);
    b_re_o  = sat((tr - p_re) >>> 1);
    b_im_o  = sat((ti - p_im) >>> 1);
  end

endmodule

// File: rtl/ifft_serial.sv
// Memory-based radix-2 inverse FFT: bit-reversed load, K in-place DIT stages through one
// time-shared butterfly, natural-order unload with an overall 1/N scale.
module ifft_serial
  import ifft_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N     = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_real,
  input  logic [WIDTH-1:0] in_imag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_real,
  output logic [WIDTH-1:0] out_imag,
  output logic             out_last,
  output logic             busy
);

  localparam int unsigned K       = $clog2(N);
  localparam int unsigned AW      = K;
  localparam int unsigned BW      = K - 1;
  localparam int unsigned SW      = $clog2(K);
  localparam int unsigned TW_FRAC = tw_frac(WIDTH);

  ifft_state_e   state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [BW-1:0] bfly_q, bfly_d;

  logic [WIDTH-1:0] mem_re [N];
  logic [WIDTH-1:0] mem_im [N];

  logic [WIDTH-1:0] tw_re_tab [N/2];
  logic [WIDTH-1:0] tw_im_tab [N/2];

  for (genvar m = 0; m < int'(N / 2); m++) begin : g_tw
    localparam int CosV = tw_value(m, N, TW_FRAC, 1'b0);
    localparam int SinV = tw_value(m, N, TW_FRAC, 1'b1);
    assign tw_re_tab[m] = WIDTH'(CosV);
    assign tw_im_tab[m] = WIDTH'(SinV);
  end

  logic [AW-1:0]    b_ext, mask, top_addr, bot_addr, load_addr;
  logic [BW-1:0]    tw_idx;
  logic             load_we, bfly_we;
  logic [WIDTH-1:0] a_re, a_im, b_re, b_im;

  // top inserts a 0 at bit s of the butterfly index; bot sets that bit.
  always_comb begin
    b_ext     = {1'b0, bfly_q};
    mask      = (AW'(1) << stage_q) - AW'(1);
    top_addr  = ((b_ext & ~mask) << 1) | (b_ext & mask);
    bot_addr  = top_addr | (AW'(1) << stage_q);
    tw_idx    = BW'((b_ext & mask) << (SW'(K - 1) - stage_q));
    load_addr = AW'(bitrev(32'(cnt_q), K));
  end

  ifft_butterfly #(
    .WIDTH   (WIDTH),
    .TW_FRAC (TW_FRAC)
  ) u_bfly (
    .top_re_i (mem_re[top_addr]),
    .top_im_i (mem_im[top_addr]),
    .bot_re_i (mem_re[bot_addr]),
    .bot_im_i (mem_im[bot_addr]),
    .tw_re_i  (tw_re_tab[tw_idx]),
    .tw_im_i  (tw_im_tab[tw_idx]),
    .a_re_o   (a_re),
    .a_im_o   (a_im),
    .b_re_o   (b_re),
    .b_im_o   (b_im)
  );

  always_comb begin
    in_ready  = reset_n && (state_q == StLoad);
    out_valid = (state_q == StUnload);
    busy      = (state_q != StLoad);
    out_last  = out_valid && (cnt_q == AW'(N - 1));
    out_real  = out_valid ? mem_re[cnt_q] : '0;
    out_imag  = out_valid ? mem_im[cnt_q] : '0;
    load_we   = in_valid && in_ready;
    bfly_we   = (state_q == StCompute);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    bfly_d  = bfly_q;
    case (state_q)
      StLoad: begin
        if (load_we) begin
          cnt_d = cnt_q + AW'(1);
          if (cnt_q == AW'(N - 1)) begin
            cnt_d   = '0;
            state_d = StCompute;
          end
        end
      end
      StCompute: begin
        bfly_d = bfly_q + BW'(1);
        if (bfly_q == BW'(N / 2 - 1)) begin
          bfly_d  = '0;
          stage_d = stage_q + SW'(1);
          if (stage_q == SW'(K - 1)) begin
            stage_d = '0;
            state_d = StUnload;
          end
        end
      end
      StUnload: begin
        if (out_ready) begin
          cnt_d = cnt_q + AW'(1);
          if (cnt_q == AW'(N - 1)) begin
            cnt_d   = '0;
            state_d = StLoad;
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StLoad;
      cnt_q   <= '0;
      stage_q <= '0;
      bfly_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      bfly_q  <= bfly_d;
    end
  end

  // Register file: one load port, or two butterfly ports during compute.
  always_ff @(posedge clk) begin
    if (load_we) begin
      mem_re[load_addr] <= in_real;
      mem_im[load_addr] <= in_imag;
    end
    if (bfly_we) begin
      mem_re[top_addr] <= a_re;
      mem_im[top_addr] <= a_im;
      mem_re[bot_addr] <= b_re;
      mem_im[bot_addr] <= b_im;
    end
  end

endmodule
